vga_sprite_engine: RTL and testbench
====================================

# vga_sprite_engine

Parametrised VGA timing generator and multi-sprite renderer, successor to the fixed 640x480 two-object sync block. It sits between the CPU bus (sprite register writes, vblank interrupt with ack) and the VGA pins. It adds configurable timing, N sprites with per-sprite colour and enable, and double-buffered sprite state committed at vblank so CPU updates never tear. It also adds interrupt-overrun detection.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- NUM_SPRITES, 4, sprite count (>=1)
- SPRITE_SIZE, 16, sprite edge in pixels; bitmap rows are SPRITE_SIZE bits
- RGB_W, 3, colour width
- BG_COLOR, 3'b010, colour for visible pixels not covered by any sprite
- SYNC_ACTIVE, 1, level of hsync/vsync during sync pulse
- Reset is synchronous and active-high. There is one clock, `clk`. Reset port `rst`.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  sprite register write strobe
- wr_sprite  in  $clog2(NUM_SPRITES) (min 1)  target sprite
- wr_sel  in  2  0=x, 1=y, 2=attr {enable=wr_data[15], colour=wr_data[RGB_W-1:0]}, 3=bitmap row
- wr_row  in  $clog2(SPRITE_SIZE)  bitmap row index (wr_sel=3 only)
- wr_data  in  16  write data; bitmap uses low SPRITE_SIZE bits
- ack  in  1  interrupt acknowledge
- interrupt  out  1  vblank interrupt, level, held until ack
- overrun  out  1  sticky: vblank began while interrupt still pending
- hsync, vsync  out  1  sync outputs
- de  out  1  display enable (visible region)
- rgb  out  RGB_W  pixel colour
- h_count, v_count  out  16  current raster position (pre-output-register)

## Operation
- Pixel enable `pix_en`: divider counts 0..CLK_DIV-1; pix_en=1 when count==CLK_DIV-1 (CLK_DIV=1: always 1).
- On pix_en: h_count increments, wraps to 0 at H_TOTAL-1 (sum of four H params); v_count increments on that wrap, wraps at V_TOTAL-1.
- Visible: h<H_DISPLAY && v<V_DISPLAY. hsync active for h in [H_DISPLAY+H_FRONT, +H_SYNC); vsync likewise with V params.
- Sprite i hits when enable && h>=x && h<x+SPRITE_SIZE && v>=y && v<y+SPRITE_SIZE && bitmap[v-y][h-x]. Bit 0 is the leftmost pixel. Compares use 17 bits; no wrap at x or y near 65535.
- Priority: lowest index hit wins. No hit in visible region -> BG_COLOR. Outside visible region -> 0.
- Writes go to shadow registers. Active set = shadow copied in one cycle at vblank start (pix_en && h wraps && new v == V_DISPLAY). A write in the commit cycle lands in shadow only and takes effect next frame.
- Interrupt set at vblank start. Cleared by ack while set. Set and ack in the same cycle -> stays set. ack while clear is ignored.
- overrun set if vblank start occurs with interrupt already 1. Cleared only by ack, the same cycle interrupt clears.

## Timing
- Reset: dividers/counters 0; interrupt=0, overrun=0, de=0, rgb=0, hsync=vsync=~SYNC_ACTIVE; all shadow and active sprite state 0 (disabled).
- rst mid-frame: next cycle restarts at (0,0) with divider 0. Pending interrupt is dropped.
- hsync, vsync, de, rgb are registered, updated on pix_en. They lag h_count/v_count by exactly one pixel and are stable for CLK_DIV clk cycles.
- interrupt/overrun change one clk after the triggering pix_en edge. First interrupt after reset is at the first vblank start.
- Write latency to screen: at most one frame plus one pixel after the next commit.

## Structure
- Package `vga_pkg`: default timing constants, `wr_sel_e` enum (SEL_X, SEL_Y, SEL_ATTR, SEL_ROW), `sprite_t` struct (x, y, enable, colour, bitmap array).
- Sub-module `vga_timing`: divider, counters, sync/de/vblank-start generation. Top holds sprite shadow/active banks, hit/priority logic, output registers, and interrupt logic.

## Test plan
- Small timing (H 8/2/2/2, V 6/1/1/1, CLK_DIV=2): hsync pulse 2 pixels = 4 clk starting at h=10. Frame = 14x9 pixels = 252 clk.
- Sprite 0 at (2,1), bitmap row0=0x0001, colour 3'b100, enabled, committed: rgb=3'b100 only for pixel (2,1). Rest of visible region = 3'b010. Blanking rgb=0.
- Sprites 0 and 1 overlap at the same pixel with colours 100/001: rgb=100. Disable sprite 0: rgb=001 from next frame.
- Write x mid-frame: current frame unchanged. New position appears the frame after vblank start. Write in the exact commit cycle is deferred one more frame.
- No ack across two vblank starts: interrupt=1, overrun=1. ack coincident with vblank start: interrupt stays 1. Later ack clears both.
- Assert rst for 1 cycle mid-line: counters 0, outputs at reset values, interrupt 0. Timing resumes correctly.

Source files
------------

// File: rtl/vga_sprite_engine_pkg.sv
// vga_pkg: shared constants and types for the VGA sprite engine.
//   - Default 640x480 timing constants.
//   - wr_sel_e: register select for CPU sprite writes.
//   - sprite_t: one sprite's position, attributes and bitmap.
//   - in_span(): 17-bit range test used for sprite hit detection.
package vga_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // The sprite record is sized by these; the top checks its parameters against them.
    localparam int SPR_SIZE  = 16;
    localparam int SPR_RGB_W = 3;

    typedef enum logic [1:0] {
        SEL_X    = 2'd0,
        SEL_Y    = 2'd1,
        SEL_ATTR = 2'd2,
        SEL_ROW  = 2'd3
    } wr_sel_e;

    typedef struct packed {
        logic [15:0]                        x;
        logic [15:0]                        y;
        logic                               enable;
        logic [SPR_RGB_W-1:0]               colour;
        logic [SPR_SIZE-1:0][SPR_SIZE-1:0]  bitmap;  // [row][col], col 0 = leftmost
    } sprite_t;

    // pos in [origin, origin+size), evaluated in 17 bits so a sprite near
    // 65535 never wraps around to cover low coordinates.
    function automatic logic in_span(input logic [15:0] pos,
                                     input logic [15:0] origin,
                                     input int          size);
        logic [16:0] p;
        logic [16:0] lo;
        logic [16:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, origin};
        hi = lo + 17'(size);
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/vga_sprite_engine_if.sv
// CPU-side bus of the sprite engine: sprite register writes plus the
// vblank interrupt / acknowledge pair.
//   master: CPU (drives wr_*, ack; observes interrupt, overrun)
//   slave : engine (observes wr_*, ack; drives interrupt, overrun)
interface vga_sprite_engine_if #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 16
);
    import vga_pkg::*;

    localparam int SPR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int ROW_W = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;

    logic             wr_en;
    logic [SPR_W-1:0] wr_sprite;
    wr_sel_e          wr_sel;
    logic [ROW_W-1:0] wr_row;
    logic [15:0]      wr_data;
    logic             ack;
    logic             interrupt;
    logic             overrun;

    modport master (
        output wr_en, wr_sprite, wr_sel, wr_row, wr_data, ack,
        input  interrupt, overrun
    );

    modport slave (
        input  wr_en, wr_sprite, wr_sel, wr_row, wr_data, ack,
        output interrupt, overrun
    );

endinterface

// File: rtl/vga_sprite_engine_timing.sv
// vga_timing: pixel-rate divider and raster counters.
//   clk, rst      : system clock, synchronous active-high reset
//   pix_en        : one clk-wide strobe per pixel
//   h_count/v_count: current raster position
//   visible       : position lies in the displayed area
//   hs_pulse/vs_pulse: position lies inside the sync pulse (polarity-free)
//   vblank_start  : pixel strobe on which v_count moves into the first blank line
module vga_timing #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [15:0] h_count,
    output logic [15:0] v_count,
    output logic        visible,
    output logic        hs_pulse,
    output logic        vs_pulse,
    output logic        vblank_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    logic h_end;
    logic v_end;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            logic [DW-1:0] div_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    div_cnt <= '0;
                end else if (div_cnt == DW'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            assign pix_en = (div_cnt == DW'(CLK_DIV - 1));
        end
    endgenerate

    assign h_end = (h_count == 16'(H_TOTAL - 1));
    assign v_end = (v_count == 16'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_en) begin
            if (h_end) begin
                h_count <= '0;
                v_count <= v_end ? 16'd0 : v_count + 16'd1;
            end else begin
                h_count <= h_count + 16'd1;
            end
        end
    end

    assign visible  = (h_count < 16'(H_DISPLAY)) && (v_count < 16'(V_DISPLAY));
    assign hs_pulse = (h_count >= 16'(H_DISPLAY + H_FRONT)) &&
                      (h_count <  16'(H_DISPLAY + H_FRONT + H_SYNC));
    assign vs_pulse = (v_count >= 16'(V_DISPLAY + V_FRONT)) &&
                      (v_count <  16'(V_DISPLAY + V_FRONT + V_SYNC));

    // The line wrap that carries v_count from the last visible line into blanking.
    assign vblank_start = pix_en && h_end && (v_count == 16'(V_DISPLAY - 1));

endmodule

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: VGA timing plus an N-sprite renderer with CPU-written,
// double-buffered sprite registers and a vblank interrupt.
//   clk, rst         : system clock, synchronous active-high reset
//   bus (slave)      : wr_en/wr_sprite/wr_sel/wr_row/wr_data sprite writes,
//                      ack in, interrupt/overrun out
//   hsync, vsync, de : registered sync and display-enable, one pixel behind h/v_count
//   rgb              : registered pixel colour
//   h_count, v_count : current raster position
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY   = H_DISPLAY_DEF,
    parameter int   H_FRONT     = H_FRONT_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BACK      = H_BACK_DEF,
    parameter int   V_DISPLAY   = V_DISPLAY_DEF,
    parameter int   V_FRONT     = V_FRONT_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BACK      = V_BACK_DEF,
    parameter int   CLK_DIV     = 2,
    parameter int   NUM_SPRITES = 4,
    parameter int   SPRITE_SIZE = SPR_SIZE,
    parameter int   RGB_W       = SPR_RGB_W,
    parameter logic [RGB_W-1:0] BG_COLOR = 3'b010,
    parameter logic SYNC_ACTIVE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    vga_sprite_engine_if.slave bus,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [RGB_W-1:0]   rgb,
    output logic [15:0]        h_count,
    output logic [15:0]        v_count
);

    localparam int ROW_W = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;

    generate
        if (SPRITE_SIZE != SPR_SIZE || RGB_W != SPR_RGB_W) begin : g_bad_cfg
            $error("SPRITE_SIZE/RGB_W must match the sprite_t layout in vga_pkg");
        end
    endgenerate

    logic pix_en;
    logic visible;
    logic hs_pulse;
    logic vs_pulse;
    logic vblank_start;

    vga_timing #(
        .H_DISPLAY (H_DISPLAY),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_DISPLAY (V_DISPLAY),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CLK_DIV   (CLK_DIV)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (pix_en),
        .h_count      (h_count),
        .v_count      (v_count),
        .visible      (visible),
        .hs_pulse     (hs_pulse),
        .vs_pulse     (vs_pulse),
        .vblank_start (vblank_start)
    );

    sprite_t shadow [NUM_SPRITES];
    sprite_t active [NUM_SPRITES];

    // CPU writes always land in the shadow bank. The active bank is reloaded
    // from the pre-write shadow on vblank_start, so a write in that very cycle
    // waits for the following frame's commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (vblank_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (bus.wr_en && (int'(bus.wr_sprite) < NUM_SPRITES)) begin
                case (bus.wr_sel)
                    SEL_X:    shadow[bus.wr_sprite].x <= bus.wr_data;
                    SEL_Y:    shadow[bus.wr_sprite].y <= bus.wr_data;
                    SEL_ATTR: begin
                        shadow[bus.wr_sprite].enable <= bus.wr_data[15];
                        shadow[bus.wr_sprite].colour <= bus.wr_data[RGB_W-1:0];
                    end
                    SEL_ROW:  shadow[bus.wr_sprite].bitmap[bus.wr_row] <=
                                  bus.wr_data[SPRITE_SIZE-1:0];
                endcase
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit;
    logic [RGB_W-1:0]       pix_color_p0;

    // Scan from the highest index down so the lowest-index hit is the last
    // assignment and therefore wins.
    always_comb begin
        hit          = '0;
        pix_color_p0 = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            hit[i] = active[i].enable &&
                     in_span(h_count, active[i].x, SPRITE_SIZE) &&
                     in_span(v_count, active[i].y, SPRITE_SIZE) &&
                     active[i].bitmap[ROW_W'(v_count - active[i].y)]
                                     [ROW_W'(h_count - active[i].x)];
            if (hit[i]) begin
                pix_color_p0 = active[i].colour;
            end
        end
    end

    // ---- output register stage: one pixel behind h_count/v_count ----
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
            de    <= 1'b0;
            rgb   <= '0;
        end else if (pix_en) begin
            hsync <= hs_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= vs_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            de    <= visible;
            rgb   <= visible ? pix_color_p0 : '0;
        end
    end

    // A new vblank beats a coincident ack; overrun records a vblank that
    // arrived while the previous one was still unacknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.interrupt <= 1'b0;
            bus.overrun   <= 1'b0;
        end else if (vblank_start) begin
            bus.interrupt <= 1'b1;
            if (bus.interrupt) begin
                bus.overrun <= 1'b1;
            end
        end else if (bus.ack && bus.interrupt) begin
            bus.interrupt <= 1'b0;
            bus.overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a small 14x9-pixel raster with CLK_DIV=2.
// A frame-level model derives every output from the number of clk edges
// since reset and from the sprite table the CPU has written; a compare
// process checks all outputs on every negedge, and directed literals pin
// specific pixels, sync edges and interrupt behaviour.
module tb_vga_sprite_engine;
    import vga_pkg::*;

    localparam int HD = 8, HF = 2, HS = 2, HB = 2;
    localparam int VD = 6, VF = 1, VS = 1, VB = 1;
    localparam int DIV = 2, NS = 4, SS = 16;
    localparam int HT = HD + HF + HS + HB;    // 14
    localparam int VT = VD + VF + VS + VB;    // 9
    localparam int FRAME = HT * VT;           // 126 pixels = 252 clk
    localparam int VB_PIX = (VD - 1) * HT + (HT - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sprite_engine_if #(.NUM_SPRITES(NS), .SPRITE_SIZE(SS)) bus();

    logic        hsync, vsync, de;
    logic [2:0]  rgb;
    logic [15:0] h_count, v_count;

    vga_sprite_engine #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(DIV), .NUM_SPRITES(NS), .SPRITE_SIZE(SS), .RGB_W(3),
        .BG_COLOR(3'b010), .SYNC_ACTIVE(1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .hsync   (hsync),
        .vsync   (vsync),
        .de      (de),
        .rgb     (rgb),
        .h_count (h_count),
        .v_count (v_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int        m_e = 0;        // clk edges since reset released
    int        last_q = -1;    // last pixel whose outputs are on the pins
    bit        m_started = 0;
    bit        m_int = 0, m_ovr = 0;
    logic      exp_hs = 0, exp_vs = 0, exp_de = 0;
    logic [2:0] exp_rgb = 0;
    int        m_q;
    bit        m_vb;

    int        s_x [NS], s_y [NS], a_x [NS], a_y [NS];
    bit        s_en [NS], a_en [NS];
    bit [2:0]  s_col [NS], a_col [NS];
    bit [15:0] s_bmp [NS][SS];
    bit [15:0] a_bmp [NS][SS];

    function automatic int pix(input int f, input int v, input int h);
        return f * FRAME + v * HT + h;
    endfunction

    // {hsync, vsync, de, rgb} for absolute pixel q using the committed table.
    function automatic logic [5:0] render(input int q);
        int h, v;
        bit vis, found;
        logic [2:0] c;
        h = q % HT;
        v = (q / HT) % VT;
        vis = (h < HD) && (v < VD);
        c = 3'b000;
        found = 0;
        if (vis) begin
            c = 3'b010;
            for (int i = 0; i < NS; i++) begin
                if (!found && a_en[i] && h >= a_x[i] && h < a_x[i] + SS &&
                    v >= a_y[i] && v < a_y[i] + SS && a_bmp[i][v - a_y[i]][h - a_x[i]]) begin
                    c = a_col[i];
                    found = 1;
                end
            end
        end
        return {(h >= HD + HF && h < HD + HF + HS), (v >= VD + VF && v < VD + VF + VS), vis, c};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_e = 0; last_q = -1; m_int = 0; m_ovr = 0; m_started = 1;
            exp_hs = 0; exp_vs = 0; exp_de = 0; exp_rgb = 0;
            for (int i = 0; i < NS; i++) begin
                s_x[i] = 0; s_y[i] = 0; s_en[i] = 0; s_col[i] = 0;
                a_x[i] = 0; a_y[i] = 0; a_en[i] = 0; a_col[i] = 0;
                for (int r = 0; r < SS; r++) begin
                    s_bmp[i][r] = 0; a_bmp[i][r] = 0;
                end
            end
        end else begin
            m_vb = 0;
            if (m_e % DIV == DIV - 1) begin
                m_q = m_e / DIV;
                {exp_hs, exp_vs, exp_de, exp_rgb} = render(m_q);
                last_q = m_q;
                m_vb = (m_q % FRAME) == VB_PIX;
                if (m_vb) begin
                    a_x = s_x; a_y = s_y; a_en = s_en; a_col = s_col; a_bmp = s_bmp;
                end
            end
            if (m_vb) begin
                m_ovr = m_ovr | m_int;
                m_int = 1;
            end else if (bus.ack && m_int) begin
                m_int = 0;
                m_ovr = 0;
            end
            if (bus.wr_en) begin
                case (bus.wr_sel)
                    SEL_X:    s_x[bus.wr_sprite] = int'(bus.wr_data);
                    SEL_Y:    s_y[bus.wr_sprite] = int'(bus.wr_data);
                    SEL_ATTR: begin
                        s_en[bus.wr_sprite]  = bus.wr_data[15];
                        s_col[bus.wr_sprite] = bus.wr_data[2:0];
                    end
                    SEL_ROW:  s_bmp[bus.wr_sprite][bus.wr_row] = bus.wr_data;
                endcase
            end
            m_e++;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("h_count",   32'(h_count), 32'((m_e / DIV) % HT));
            chk("v_count",   32'(v_count), 32'(((m_e / DIV) / HT) % VT));
            chk("hsync",     32'(hsync), 32'(exp_hs));
            chk("vsync",     32'(vsync), 32'(exp_vs));
            chk("de",        32'(de), 32'(exp_de));
            chk("rgb",       32'(rgb), 32'(exp_rgb));
            chk("interrupt", 32'(bus.interrupt), 32'(m_int));
            chk("overrun",   32'(bus.overrun), 32'(m_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pix(input int q);
        int n = 0;
        while (last_q != q && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (last_q != q) begin
            checks++; errors++;
            $display("FAIL wait_pix actual=%0d required=%0d", last_q, q);
        end
    endtask

    task automatic wait_e(input int target);
        int n = 0;
        while (m_e != target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (m_e != target) begin
            checks++; errors++;
            $display("FAIL wait_edge actual=%0d required=%0d", m_e, target);
        end
    endtask

    task automatic wr(input int spr, input wr_sel_e sel, input int row, input logic [15:0] data);
        bus.wr_en = 1'b1; bus.wr_sprite = 2'(spr); bus.wr_sel = sel;
        bus.wr_row = 4'(row); bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_sprite = 0; bus.wr_sel = SEL_X;
        bus.wr_row = 0; bus.wr_data = 0; bus.ack = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hcount", 32'(h_count), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_int", 32'(bus.interrupt), 32'd0);
        rst = 1'b0;

        // sprite 0 at (2,1), single pixel, colour 100
        wr(0, SEL_X, 0, 16'd2);
        wr(0, SEL_Y, 0, 16'd1);
        wr(0, SEL_ROW, 0, 16'h0001);
        wr(0, SEL_ATTR, 0, 16'h8004);

        wait_pix(9);  chk("hs_before", 32'(hsync), 32'd0);
        wait_pix(10); chk("hs_start", 32'(hsync), 32'd1);
                      chk("lag_hcount", 32'(h_count), 32'd11);
        wait_pix(11); chk("hs_second", 32'(hsync), 32'd1);
        wait_pix(12); chk("hs_end", 32'(hsync), 32'd0);
        wait_pix(pix(0, 1, 2)); chk("f0_uncommitted", 32'(rgb), 32'h2);
        wait_pix(84); chk("first_irq", 32'(bus.interrupt), 32'd1);
        wait_pix(pix(0, 7, 0)); chk("vs_active", 32'(vsync), 32'd1);

        wait_pix(pix(1, 0, 0)); pulse_ack();
        chk("ack_clears", 32'(bus.interrupt), 32'd0);
        wait_pix(pix(1, 1, 1)); chk("f1_left", 32'(rgb), 32'h2);
        wait_pix(pix(1, 1, 2)); chk("f1_spr0", 32'(rgb), 32'h4);
                                chk("model_spr0", 32'(exp_rgb), 32'h4);
        wait_pix(pix(1, 1, 3)); chk("f1_right", 32'(rgb), 32'h2);
        wait_pix(pix(1, 1, 9)); chk("f1_blank", 32'(rgb), 32'h0);

        // sprite 1 overlapping at (2,1), colour 001
        wr(1, SEL_X, 0, 16'd2);
        wr(1, SEL_Y, 0, 16'd1);
        wr(1, SEL_ROW, 0, 16'h0001);
        wr(1, SEL_ATTR, 0, 16'h8001);

        wait_pix(pix(2, 1, 2)); chk("prio_low_wins", 32'(rgb), 32'h4);
        wr(0, SEL_ATTR, 0, 16'h0004);
        wait_pix(pix(2, 6, 0));
        chk("two_vb_int", 32'(bus.interrupt), 32'd1);
        chk("two_vb_ovr", 32'(bus.overrun), 32'd1);

        // mid-frame x move is invisible until the next commit
        wait_pix(pix(3, 0, 0)); wr(1, SEL_X, 0, 16'd5);
        wait_pix(pix(3, 1, 2)); chk("disabled_s0", 32'(rgb), 32'h1);
                                chk("model_s1", 32'(exp_rgb), 32'h1);
        wait_pix(pix(3, 1, 5)); chk("move_pending", 32'(rgb), 32'h2);

        // ack in the vblank-start cycle loses to the new vblank
        wait_e(2 * pix(3, 5, 13) + 1); pulse_ack();
        chk("ack_vb_int", 32'(bus.interrupt), 32'd1);
        chk("ack_vb_ovr", 32'(bus.overrun), 32'd1);
        wait_pix(pix(4, 0, 0)); pulse_ack();
        chk("ack2_int", 32'(bus.interrupt), 32'd0);
        chk("ack2_ovr", 32'(bus.overrun), 32'd0);
        wait_pix(pix(4, 1, 2)); chk("moved_old", 32'(rgb), 32'h2);
        wait_pix(pix(4, 1, 5)); chk("moved_new", 32'(rgb), 32'h1);

        // write landing exactly in the commit cycle is deferred one frame
        wait_e(2 * pix(4, 5, 13) + 1); wr(1, SEL_X, 0, 16'd6);
        wait_pix(pix(5, 1, 5)); chk("commit_wr_defer", 32'(rgb), 32'h1);
        wait_pix(pix(5, 1, 6)); chk("commit_wr_bg", 32'(rgb), 32'h2);
        wait_pix(pix(6, 1, 5)); chk("commit_wr_old", 32'(rgb), 32'h2);
        wait_pix(pix(6, 1, 6)); chk("commit_wr_new", 32'(rgb), 32'h1);

        // single-cycle reset mid-line
        wait_pix(pix(6, 2, 3));
        chk("pre_rst_int", 32'(bus.interrupt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_h", 32'(h_count), 32'd0);
        chk("mrst_v", 32'(v_count), 32'd0);
        chk("mrst_rgb", 32'(rgb), 32'd0);
        chk("mrst_de", 32'(de), 32'd0);
        chk("mrst_hs", 32'(hsync), 32'd0);
        chk("mrst_vs", 32'(vsync), 32'd0);
        chk("mrst_int", 32'(bus.interrupt), 32'd0);
        chk("mrst_ovr", 32'(bus.overrun), 32'd0);
        rst = 1'b0;

        wait_pix(9);  chk("r_hs_before", 32'(hsync), 32'd0);
        wait_pix(10); chk("r_hs_start", 32'(hsync), 32'd1);
                      chk("r_lag", 32'(h_count), 32'd11);
        wait_pix(pix(0, 1, 2)); chk("r_cleared", 32'(rgb), 32'h2);
        wait_pix(82); chk("r_no_irq", 32'(bus.interrupt), 32'd0);
        wait_pix(84); chk("r_irq", 32'(bus.interrupt), 32'd1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
